// File: rtl/screen_ram_arbiter.sv
// Arbitrates one single-port screen RAM between VGA scan-out reads and buffered CPU writes.
// Build option SCREEN_RAM_WB_FIFO_EN: 4-entry write FIFO instead of the default 1-entry holding register.
module screen_ram_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [WIDTH-1:0]      vga_rdata,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic                  cpu_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VGA  = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SW-1:0]         r_starve_cnt;
    logic                  r_cpu_ready;
    logic [WIDTH-1:0]      r_rdata_hold;

    logic                  w_push;
    logic                  w_vga_gnt;
    logic                  w_drain;
    logic                  w_rvalid;
    logic                  w_buf_nonempty;
    logic                  w_full_next;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [WIDTH-1:0]      w_head_data;

    // A starved CPU write wins exactly one slot once the VGA has taken STARVE_LIMIT in a row.
    assign w_push    = cpu_we & r_cpu_ready;
    assign w_vga_gnt = ~rst & vga_req & ~((r_starve_cnt == STARVE_MAX) & w_buf_nonempty);
    assign w_drain   = ~rst & w_buf_nonempty & ~w_vga_gnt;

`ifdef SCREEN_RAM_WB_FIFO_EN
    logic [ADDR_WIDTH-1:0] r_fifo_addr [4];
    logic [WIDTH-1:0]      r_fifo_data [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic [2:0]            w_count_next;

    assign w_buf_nonempty = (r_count != 3'd0);
    assign w_head_addr    = r_fifo_addr[r_rd_ptr];
    assign w_head_data    = r_fifo_data[r_rd_ptr];

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (no latch).
        w_count_next = r_count;
        case ({w_push, w_drain})
            2'b10:   w_count_next = r_count + 3'd1;
            2'b01:   w_count_next = r_count - 3'd1;
            default: w_count_next = r_count;
        endcase
    end

    assign w_full_next = (w_count_next == 3'd4);

    // NOTE: storage is not reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= w_count_next;
        end
    end
`else
    logic                  r_hold_valid;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [WIDTH-1:0]      r_hold_data;

    assign w_buf_nonempty = r_hold_valid;
    assign w_head_addr    = r_hold_addr;
    assign w_head_data    = r_hold_data;
    assign w_full_next    = (r_hold_valid & ~w_drain) | w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hold_addr <= cpu_addr;
            r_hold_data <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
        end else begin
            r_hold_valid <= (r_hold_valid & ~w_drain) | w_push;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_drain || !w_buf_nonempty) begin
            r_starve_cnt <= '0;
        end else if (w_vga_gnt && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_ready <= 1'b1;
        end else begin
            r_cpu_ready <= ~w_full_next;
        end
    end

    // The state records which access was issued, so S_VGA marks the read-data return cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (w_vga_gnt) begin
            w_state_next = S_VGA;
        end else if (w_drain) begin
            w_state_next = S_CPU;
        end
    end

    always_comb begin
        w_rvalid = 1'b0;
        if ((r_state == S_VGA) && !rst) begin
            w_rvalid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= '0;
        end else if (w_rvalid) begin
            r_rdata_hold <= ram_rdata;
        end
    end

    assign vga_gnt    = w_vga_gnt;
    assign vga_rvalid = w_rvalid;
    assign vga_rdata  = w_rvalid ? ram_rdata : r_rdata_hold;
    assign cpu_ready  = r_cpu_ready;
    assign ram_addr   = w_vga_gnt ? vga_addr : w_head_addr;
    assign ram_we     = w_drain;
    assign ram_wdata  = w_head_data;

endmodule

// File: doc/screen_ram_arbiter.md
SCREEN_RAM_ARBITER -- requirements
Module: screen_ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, RAM data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM word address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, maximum consecutive VGA grants while a CPU write is pending.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port vga_req, input, 1, scan-out read request.
REQ-007 SHALL have port vga_addr, input, ADDR_WIDTH, scan-out read address.
REQ-008 SHALL have port vga_gnt, output, 1, vga_req granted this cycle (combinational).
REQ-009 SHALL have port vga_rvalid, output, 1, vga_rdata valid.
REQ-010 SHALL have port vga_rdata, output, WIDTH, read data.
REQ-011 SHALL have port cpu_we, input, 1, CPU write strobe.
REQ-012 SHALL have port cpu_addr, input, ADDR_WIDTH, CPU write address.
REQ-013 SHALL have port cpu_wdata, input, WIDTH, CPU write data.
REQ-014 SHALL have port cpu_ready, output, 1, write buffer can accept (registered).
REQ-015 SHALL have port ram_addr, output, ADDR_WIDTH, RAM address.
REQ-016 SHALL have port ram_we, output, 1, RAM write enable.
REQ-017 SHALL have port ram_wdata, output, WIDTH, RAM write data.
REQ-018 SHALL have port ram_rdata, input, WIDTH, RAM read data, one-cycle latency.

Function
REQ-019 SHALL issue at most one RAM access per cycle: a VGA read, a CPU buffer drain, or none.
REQ-020 SHALL accept a CPU write when cpu_we=1 and cpu_ready=1; cpu_we while cpu_ready=0 is ignored.
REQ-021 SHALL run FSM states IDLE, VGA, CPU, recording the access made this cycle; next state = VGA on VGA grant, CPU on drain, else IDLE.
REQ-022 SHALL grant VGA when vga_req=1 unless starve_cnt==STARVE_LIMIT and the buffer is non-empty.
REQ-023 SHALL drain the buffer head (ram_we=1, ram_addr/ram_wdata = head) when the buffer is non-empty and VGA is not granted.
REQ-024 SHALL increment starve_cnt on each VGA grant while the buffer is non-empty, clear it on every drain or when the buffer is empty, and saturate at STARVE_LIMIT.
REQ-025 SHALL assert vga_rvalid exactly one cycle after vga_gnt with vga_rdata=ram_rdata, and hold vga_rdata at its last value otherwise.
REQ-026 SHALL drive ram_we=0 and ram_addr=vga_addr during VGA grants; ram_wdata is don't-care when ram_we=0.
REQ-027 SHALL not forward buffered data to VGA reads; a read returns RAM contents at read time.
REQ-028 SHALL drain writes in acceptance order; same-address writes land last-wins.
REQ-029 SHALL compute cpu_ready = not full after the current cycle's push/pop; push and drain in the same cycle is allowed.

Reset
REQ-030 SHALL on rst=1 at a clock edge: FSM=IDLE, buffer empty, starve_cnt=0, vga_rvalid=0, vga_rdata=0, cpu_ready=1.
REQ-031 SHALL force vga_gnt=0 and ram_we=0 while rst=1.
REQ-032 SHALL discard buffered and in-flight writes and suppress a pending vga_rvalid when reset asserts mid-operation.

Configuration
REQ-033 SHALL, with SCREEN_RAM_WB_FIFO_EN defined, use a 4-entry circular write FIFO with 2-bit wrapping pointers and a 3-bit count.
REQ-034 SHALL, without SCREEN_RAM_WB_FIFO_EN, use a 1-entry holding register; cpu_ready=0 while it is occupied and not being drained.

Verification
REQ-035 SHALL check: vga_req=1, vga_addr=16'h0100, RAM[0x100]=32'h12345678 -> vga_gnt same cycle, vga_rvalid=1 and vga_rdata=32'h12345678 next cycle.
REQ-036 SHALL check: vga_req=0, single CPU write 0x0200<=32'hCAFEF00D -> ram_we=1, ram_addr=0x0200 on the cycle after acceptance.
REQ-037 SHALL check: vga_req held high and one CPU write pending -> 8 VGA grants, 1 drain with vga_gnt=0, then VGA resumes.
REQ-038 SHALL check, with FIFO enabled: 5 back-to-back cpu_we under continuous vga_req -> cpu_ready=0 after 4 accepts; drains in order 1..4.
REQ-039 SHALL check: 2 writes buffered, rst pulsed 1 cycle -> no ram_we afterwards, cpu_ready=1, vga_rvalid=0.
REQ-040 SHALL check: write 0x0300<=A then VGA read 0x0300 before drain -> old RAM value returned; read after drain returns A.
